// File: rtl/axi_narrow_upsizer_pkg.sv
// Shared types and the byte-offset stepping helper for the 32->128 bit AXI upsizer.
// Used by axi_narrow_upsizer and its read lane tracker.
package axi_narrow_upsizer_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef struct packed {
    logic [3:0] offset;
    logic [2:0] size;
    logic [1:0] burst;
  } rd_entry_t;

  // Sizes wider than the narrow bus clamp to 4 bytes; WRAP and reserved bursts step like INCR.
  function automatic logic [3:0] next_offset(input logic [3:0] offset,
                                             input logic [2:0] size,
                                             input logic [1:0] burst);
    logic [2:0] effSize;
    effSize = (size > 3'd2) ? 3'd2 : size;
    if (burst == FIXED) return offset;
    return offset + (4'd1 << effSize);
  endfunction

endpackage

// File: rtl/axi_narrow_upsizer_rd_tracker.sv
// FIFO of accepted-but-uncompleted read bursts, remembering each burst's starting lane.
// Full/empty are registered so a pop never frees a slot in the same cycle.
module axi_narrow_upsizer_rd_tracker
  import axi_narrow_upsizer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  rd_entry_t pushEntry,
  input  logic      pop,
  output rd_entry_t headEntry,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rd_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count, countNext;
  logic             doPush, doPop;

  assign doPush    = push && !full;
  assign doPop     = pop && !empty;
  assign headEntry = mem[rdPtr];

  always_comb begin
    countNext = count;
    case ({doPush, doPop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
      if (doPop)  rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
      count <= countNext;
      full  <= (countNext == CNT_W'(DEPTH));
      empty <= (countNext == '0);
    end
  end

endmodule

// File: rtl/axi_narrow_upsizer.sv
// Bridges a 32-bit AXI4 master onto a 128-bit AXI4 RAM using narrow transfers with lane steering.
// Write path is built only when AXI_NARROW_UPSIZER_WRITE_EN is defined; reads are always present.
module axi_narrow_upsizer
  import axi_narrow_upsizer_pkg::*;
#(
  parameter int RD_OUTSTANDING = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_aw_valid,
  output logic              s_aw_ready,
  input  logic [ADDR_W-1:0] s_aw_addr,
  input  logic [7:0]        s_aw_len,
  input  logic [2:0]        s_aw_size,
  input  logic [1:0]        s_aw_burst,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [7:0]        m_aw_len,
  output logic [2:0]        m_aw_size,
  output logic [1:0]        m_aw_burst,
  input  logic              s_w_valid,
  output logic              s_w_ready,
  input  logic [31:0]       s_w_data,
  input  logic [3:0]        s_w_strb,
  input  logic              s_w_last,
  output logic              m_w_valid,
  input  logic              m_w_ready,
  output logic [127:0]      m_w_data,
  output logic [15:0]       m_w_strb,
  output logic              m_w_last,
  output logic              s_b_valid,
  input  logic              s_b_ready,
  output logic [1:0]        s_b_resp,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  input  logic [1:0]        m_b_resp,
  input  logic              s_ar_valid,
  output logic              s_ar_ready,
  input  logic [ADDR_W-1:0] s_ar_addr,
  input  logic [7:0]        s_ar_len,
  input  logic [2:0]        s_ar_size,
  input  logic [1:0]        s_ar_burst,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [7:0]        m_ar_len,
  output logic [2:0]        m_ar_size,
  output logic [1:0]        m_ar_burst,
  output logic              s_r_valid,
  input  logic              s_r_ready,
  output logic [31:0]       s_r_data,
  output logic [1:0]        s_r_resp,
  output logic              s_r_last,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [127:0]      m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_last
);

  rd_entry_t  headEntry, pushEntry;
  logic       trkFull, trkEmpty, arGo, arPush, rBeat, rPop;
  logic       rdActive;
  logic [3:0] rdOff;

  assign arGo       = reset && !trkFull;
  assign m_ar_valid = s_ar_valid && arGo;
  assign s_ar_ready = m_ar_ready && arGo;
  assign m_ar_addr  = s_ar_addr;
  assign m_ar_len   = s_ar_len;
  assign m_ar_size  = s_ar_size;
  assign m_ar_burst = s_ar_burst;
  assign arPush     = s_ar_valid && s_ar_ready;
  assign pushEntry  = '{offset: s_ar_addr[3:0], size: s_ar_size, burst: s_ar_burst};

  assign s_r_valid = reset && rdActive && m_r_valid;
  assign m_r_ready = reset && rdActive && s_r_ready;
  assign s_r_data  = m_r_data[{rdOff[3:2], 5'd0} +: 32];
  assign s_r_resp  = m_r_resp;
  assign s_r_last  = m_r_last;
  assign rBeat     = s_r_valid && s_r_ready;
  assign rPop      = rBeat && m_r_last;

  axi_narrow_upsizer_rd_tracker #(.DEPTH(RD_OUTSTANDING)) rdTracker (
    .clk       (clk),
    .reset     (reset),
    .push      (arPush),
    .pushEntry (pushEntry),
    .pop       (rPop),
    .headEntry (headEntry),
    .full      (trkFull),
    .empty     (trkEmpty)
  );

  // Head entry is loaded in its own cycle before R is opened, giving the per-burst bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdActive <= 1'b0;
      rdOff    <= '0;
    end else if (!rdActive) begin
      if (!trkEmpty) begin
        rdOff    <= headEntry.offset;
        rdActive <= 1'b1;
      end
    end else if (rBeat) begin
      if (m_r_last) rdActive <= 1'b0;
      else          rdOff    <= next_offset(rdOff, headEntry.size, headEntry.burst);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && arPush && s_ar_size > 3'd2) $error("AR size %0d wider than narrow bus", s_ar_size);
  end

`ifdef AXI_NARROW_UPSIZER_WRITE_EN
  wr_state_e  wrState;
  logic [3:0] wrOff;
  logic [2:0] wrSize;
  logic [1:0] wrBurst;

  assign s_aw_ready = reset && (wrState == W_IDLE) && m_aw_ready;
  assign m_aw_valid = reset && (wrState == W_IDLE) && s_aw_valid;
  assign m_aw_addr  = s_aw_addr;
  assign m_aw_len   = s_aw_len;
  assign m_aw_size  = s_aw_size;
  assign m_aw_burst = s_aw_burst;
  assign s_w_ready  = reset && (wrState == W_DATA) && m_w_ready;
  assign m_w_valid  = reset && (wrState == W_DATA) && s_w_valid;
  assign m_w_data   = {4{s_w_data}};
  assign m_w_strb   = {12'd0, s_w_strb} << {wrOff[3:2], 2'b00};
  assign m_w_last   = s_w_last;
  assign s_b_valid  = reset && (wrState == W_RESP) && m_b_valid;
  assign m_b_ready  = reset && (wrState == W_RESP) && s_b_ready;
  assign s_b_resp   = m_b_resp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrState <= W_IDLE;
      wrOff   <= '0;
      wrSize  <= '0;
      wrBurst <= '0;
    end else begin
      case (wrState)
        W_IDLE: if (s_aw_valid && s_aw_ready) begin
          wrOff   <= s_aw_addr[3:0];
          wrSize  <= s_aw_size;
          wrBurst <= s_aw_burst;
          wrState <= W_DATA;
          if (s_aw_size > 3'd2) $error("AW size %0d wider than narrow bus", s_aw_size);
        end
        W_DATA: if (s_w_valid && s_w_ready) begin
          wrOff <= next_offset(wrOff, wrSize, wrBurst);
          if (s_w_last) wrState <= W_RESP;
        end
        W_RESP:  if (s_b_valid && s_b_ready) wrState <= W_IDLE;
        default: wrState <= W_IDLE;
      endcase
    end
  end
`else
  logic unusedWrite;

  assign s_aw_ready  = 1'b0;
  assign m_aw_valid  = 1'b0;
  assign m_aw_addr   = '0;
  assign m_aw_len    = '0;
  assign m_aw_size   = '0;
  assign m_aw_burst  = '0;
  assign s_w_ready   = 1'b0;
  assign m_w_valid   = 1'b0;
  assign m_w_data    = '0;
  assign m_w_strb    = '0;
  assign m_w_last    = 1'b0;
  assign s_b_valid   = 1'b0;
  assign m_b_ready   = 1'b0;
  assign s_b_resp    = '0;
  assign unusedWrite = ^{s_aw_valid, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, m_aw_ready,
                         s_w_valid, s_w_data, s_w_strb, s_w_last, m_w_ready,
                         s_b_ready, m_b_valid, m_b_resp};
`endif

endmodule

// File: doc/axi_narrow_upsizer.md
# axi_narrow_upsizer

- Bridges the 32-bit AXI4 master (`axi_dpi`) to the 128-bit AXI4 on-chip RAM (`Axi4OnChipRam`); it sits between the two.
- Address channels pass through unchanged as narrow transfers (AxSIZE ≤ 2) on the wide bus.
- W data is replicated onto the wide bus and W strobes are steered into the correct 32-bit lane.
- The correct lane of R data is selected back out per beat, using per-burst byte-offset tracking.

## Interface
Parameters:
- `RD_OUTSTANDING`, default 4: depth of the read lane tracker (maximum accepted, uncompleted AR bursts).
- `ADDR_W`, default 32: address width.

Ports (`s_*` face the master, `m_*` face the RAM; payload widths follow AXI4):
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `s_aw_valid/ready/addr/len/size/burst`  in/out/in/in/in/in  1/1/ADDR_W/8/3/2  narrow write address.
- `m_aw_valid/ready/addr/len/size/burst`  out/in/out/out/out/out  same widths  wide write address.
- `s_w_valid/ready/data/strb/last`  in/out/in/in/in  1/1/32/4/1  narrow write data.
- `m_w_valid/ready/data/strb/last`  out/in/out/out/out  1/1/128/16/1  wide write data.
- `s_b_*`, `m_b_*`  valid/ready/resp  1/1/2  write response, passed through.
- `s_ar_*`, `m_ar_*`  same set as AW  read address.
- `s_r_valid/ready/data/resp/last`  out/in/out/out/out  1/1/32/2/1  narrow read data.
- `m_r_valid/ready/data/resp/last`  in/out/in/in/in  1/1/128/2/1  wide read data.

## Operation
- **Address channels:** AW and AR payloads are forwarded combinationally and unmodified. Only `valid`/`ready` are gated.
- **Byte offset:** a 4-bit byte offset is loaded from `addr[3:0]` at address handshake.
  - Each data beat handshake updates it: INCR or WRAP adds `1<<size`, modulo 16; FIXED leaves it unchanged.
  - Lane = `offset[3:2]`.
  - Size > 2 is treated as size 2, with a simulation-only `$error`.
  - WRAP is stepped as INCR.
- **Write FSM:** states W_IDLE, W_DATA, W_RESP.
  - W_IDLE: `s_aw_ready = m_aw_ready`, `m_aw_valid = s_aw_valid`. On AW handshake, load the offset and go to W_DATA.
  - W_DATA: AW is blocked (`s_aw_ready=0`, `m_aw_valid=0`). W passes through with:
    - `m_w_data = {4{s_w_data}}`
    - `m_w_strb = s_w_strb << (4*lane)`
    - `m_w_last = s_w_last`
  - Handshake with last → W_RESP.
  - W_RESP: W is blocked; B passes through. B handshake → W_IDLE.
  - W is blocked in W_IDLE: `s_w_ready=0`, `m_w_valid=0`.
- **Read path:**
  - AR is forwarded only when the tracker is not full. The AR handshake pushes {`addr[3:0]`, size, burst}.
  - `rd_active` flag and `rd_off` register:
    - When `rd_active`=0 and the tracker is not empty, load `rd_off` from the head entry and set `rd_active` (one cycle).
    - R passes only while `rd_active`=1, with `s_r_data = m_r_data[32*lane +: 32]`. `resp` and `last` pass through.
    - A last-beat handshake pops the head and clears `rd_active`.
  - While `rd_active`=0: `m_r_ready=0`, `s_r_valid=0`.
- **Simultaneous events:** a push and a pop in the same cycle are both honoured. Full is registered, so a pop never frees a slot within the same cycle.

## Timing
- Zero-cycle combinational path on all payloads and on valid/ready when not gated.
- One bubble cycle at the start of every read burst (head load). No bubble on writes.
- Reset (`reset`=0 at a clock edge): FSM → W_IDLE, tracker emptied, `rd_active`=0, offsets 0.
  - While `reset`=0, every `valid` and `ready` output is 0; payload outputs are don't-care.
  - Reset mid-burst abandons the burst silently; no response is generated.
- AW in W_IDLE with `s_aw_valid` held and `m_aw_ready`=0: nothing changes; the master holds per AXI.

## Configuration
- `AXI_NARROW_UPSIZER_WRITE_EN`:
  - Defined: full write path as above.
  - Undefined: write FSM not built; `s_aw_ready`, `s_w_ready`, `s_b_valid`, `m_aw_valid`, `m_w_valid`, `m_b_ready` tied 0; `m_*` write payloads tied 0. Read path unchanged.

## Structure
- Package `axi_narrow_upsizer_pkg`:
  - `burst_e` (FIXED=0, INCR=1, WRAP=2)
  - `wr_state_e`
  - `rd_entry_t` {offset[3:0], size[2:0], burst}
  - function `next_offset(offset, size, burst)`
- Sub-module `axi_narrow_upsizer_rd_tracker`: synchronous FIFO of `rd_entry_t`, depth `RD_OUTSTANDING`, registered full/empty flags.

## Test plan
- Write AW addr=0x104, len=3, size=2, INCR, W data 0xA0..0xA3, strb 0xF → `m_w_strb` 0x00F0, 0x0F00, 0xF000, 0x000F; B OKAY returned.
- Read the same burst (R data is a wide word with lane i = 0x1000+i) → `s_r_data` 0x1001, 0x1002, 0x1003, 0x1000; one bubble before beat 0.
- Issue 5 back-to-back ARs with `m_r_valid` held 0 → 4 accepted, `s_ar_ready`=0 on the 5th until the first burst completes.
- FIXED, size=0, addr=0x3, 2 beats → strb 0x0008 on both beats.
- `reset`=0 during W_DATA beat 2 → all valid/ready 0 the next cycle; after release a new AW is accepted immediately.
- Build without `AXI_NARROW_UPSIZER_WRITE_EN` → `s_aw_ready` stays 0 while reads complete normally.
